// File: rtl/spu_decode_stage_if.sv
// SPU-Lite decode stage: shared opcode/record package and handshake
// interfaces for the instruction input and the decoded record output.
package defines_pkg;

  localparam int OPCODE_LEN  = 11;
  localparam int REG_ADDR_WD = 7;
  localparam int INSTR_WD    = 32;

  localparam logic [2:0] FMT_RR   = 3'd0;
  localparam logic [2:0] FMT_RRR  = 3'd1;
  localparam logic [2:0] FMT_RI10 = 3'd2;
  localparam logic [2:0] FMT_RI16 = 3'd3;
  localparam logic [2:0] FMT_RI18 = 3'd4;

  typedef enum logic [3:0] {
    NOP                     = 4'd0,
    LNOP                    = 4'd1,
    ADD_WORD                = 4'd2,
    ADD_WORD_IMMEDIATE      = 4'd3,
    IMMEDIATE_LOAD_HALFWORD = 4'd4,
    IMMEDIATE_LOAD_WORD     = 4'd5,
    IMMEDIATE_LOAD_ADDRESS  = 4'd6,
    SELECT_BITS             = 4'd7
  } Opcodes;

  typedef struct packed {
    Opcodes                 opcode;
    logic [2:0]             fmt;
    logic [REG_ADDR_WD-1:0] rt;
    logic [REG_ADDR_WD-1:0] ra;
    logic [REG_ADDR_WD-1:0] rb;
    logic [REG_ADDR_WD-1:0] rc;
    logic [9:0]             i10;
    logic [15:0]            i16;
    logic [17:0]            i18;
    logic                   illegal;
  } dec_rec_t;

endpackage

interface spu_instr_if;
  import defines_pkg::*;
  logic                valid;
  logic                ready;
  logic [INSTR_WD-1:0] instr;

  modport master (output valid, output instr, input ready);
  modport slave  (input valid, input instr, output ready);
endinterface

interface spu_dec_if;
  import defines_pkg::*;
  logic                   valid;
  logic                   ready;
  Opcodes                 opcode;
  logic [2:0]             fmt;
  logic [REG_ADDR_WD-1:0] rt;
  logic [REG_ADDR_WD-1:0] ra;
  logic [REG_ADDR_WD-1:0] rb;
  logic [REG_ADDR_WD-1:0] rc;
  logic [9:0]             i10;
  logic [15:0]            i16;
  logic [17:0]            i18;
  logic                   illegal;

  modport master (
    output valid, opcode, fmt, rt, ra, rb, rc,
    output i10, i16, i18, illegal,
    input  ready
  );
  modport slave (
    input  valid, opcode, fmt, rt, ra, rb, rc,
    input  i10, i16, i18, illegal,
    output ready
  );
endinterface

// File: rtl/spu_decode_stage.sv
// SPU-Lite instruction decode stage: cracks an instruction word into
// a decoded record held in a 2-entry skid buffer.
module spu_decode_stage
  import defines_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  spu_instr_if.slave        in_if,
  spu_dec_if.master         out_if,
  output logic [15:0]       illegal_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  dec_rec_t    main_q, main_d;
  dec_rec_t    skid_q, skid_d;
  dec_rec_t    dec;
  logic [15:0] cnt_q, cnt_d;
  logic        accept;
  logic        pop;

  logic [INSTR_WD-1:0]   ins;
  logic [OPCODE_LEN-1:0] op11;
  logic [8:0]            op9;
  logic [7:0]            op8;
  logic [6:0]            op7;
  logic [3:0]            op4;

  assign ins  = in_if.instr;
  assign op11 = ins[INSTR_WD-1 -: OPCODE_LEN];
  assign op9  = ins[INSTR_WD-1 -: 9];
  assign op8  = ins[INSTR_WD-1 -: 8];
  assign op7  = ins[INSTR_WD-1 -: 7];
  assign op4  = ins[INSTR_WD-1 -: 4];

  // The opcode patterns are mutually exclusive, so a parallel match
  // gives the same result as longest-prefix-first.
  always_comb begin
    dec        = '0;
    dec.opcode = NOP;
    dec.fmt    = FMT_RR;
    unique case (1'b1)
      op11 == 11'b00011000000: begin
        dec.opcode = ADD_WORD;
        dec.rt     = ins[6:0];
        dec.ra     = ins[13:7];
        dec.rb     = ins[20:14];
      end
      op11 == 11'b00000000001: begin
        dec.opcode = LNOP;
        dec.rt     = ins[6:0];
        dec.ra     = ins[13:7];
        dec.rb     = ins[20:14];
      end
      op11 == 11'b01000000001: begin
        dec.opcode = NOP;
        dec.rt     = ins[6:0];
        dec.ra     = ins[13:7];
        dec.rb     = ins[20:14];
      end
      op9 == 9'b010000011: begin
        dec.opcode = IMMEDIATE_LOAD_HALFWORD;
        dec.fmt    = FMT_RI16;
        dec.rt     = ins[6:0];
        dec.i16    = ins[22:7];
      end
      op9 == 9'b010000001: begin
        dec.opcode = IMMEDIATE_LOAD_WORD;
        dec.fmt    = FMT_RI16;
        dec.rt     = ins[6:0];
        dec.i16    = ins[22:7];
      end
      op8 == 8'b00011100: begin
        dec.opcode = ADD_WORD_IMMEDIATE;
        dec.fmt    = FMT_RI10;
        dec.rt     = ins[6:0];
        dec.ra     = ins[13:7];
        dec.i10    = ins[23:14];
      end
      op7 == 7'b0100001: begin
        dec.opcode = IMMEDIATE_LOAD_ADDRESS;
        dec.fmt    = FMT_RI18;
        dec.rt     = ins[6:0];
        dec.i18    = ins[24:7];
      end
      op4 == 4'b1000: begin
        dec.opcode = SELECT_BITS;
        dec.fmt    = FMT_RRR;
        dec.rt     = ins[27:21];
        dec.ra     = ins[13:7];
        dec.rb     = ins[20:14];
        dec.rc     = ins[6:0];
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign in_if.ready = rst & (state_q != TWO);
  assign accept      = in_if.valid & in_if.ready;
  assign pop         = out_if.valid & out_if.ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = dec;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_d = TWO;
            skid_d  = dec;
          end else if (accept && pop) begin
            main_d  = dec;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec.illegal && !flush && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_if.valid   = (state_q != EMPTY);
  assign out_if.opcode  = main_q.opcode;
  assign out_if.fmt     = main_q.fmt;
  assign out_if.rt      = main_q.rt;
  assign out_if.ra      = main_q.ra;
  assign out_if.rb      = main_q.rb;
  assign out_if.rc      = main_q.rc;
  assign out_if.i10     = main_q.i10;
  assign out_if.i16     = main_q.i16;
  assign out_if.i18     = main_q.i18;
  assign out_if.illegal = main_q.illegal;
  assign illegal_cnt    = cnt_q;

endmodule
